// File: rtl/bus_arbiter_rr_pkg.sv
// bus_arbiter_rr_pkg: shared bus constants, arbiter defaults and FSM state type
package bus_arbiter_rr_pkg;
  localparam int BUS_DATA_W = 32;
  localparam int BUS_ADDR_W = 32;
  localparam int MASTER_NUM_DEF = 4;
  localparam int TIMEOUT_CYCLES_DEF = 255;
  typedef enum logic {IDLE, OWNED} arb_state_e;
endpackage

// File: rtl/bus_arbiter_rr_rr_pick.sv
// rr_pick: combinational round-robin pick, searching upward from last_i+1 with wrap
module rr_pick
  import bus_arbiter_rr_pkg::*;
#(
  parameter int N = MASTER_NUM_DEF,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] last_i,
  output logic [W-1:0] idx_o,
  output logic         valid_o
);
  logic [W-1:0] j;
  // walk from farthest to nearest so the nearest requester overrides
  always_comb begin
    idx_o = '0;
    j = '0;
    for (int i = N; i >= 1; i--) begin
      j = W'((int'(last_i) + i) % N);
      if (req_i[j]) idx_o = j;
    end
  end
  assign valid_o = |req_i;
endmodule

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: round-robin bus arbiter, IDLE/OWNED FSM with one turnaround cycle.
// Optional watchdog abort enabled by BUS_ARB_TIMEOUT_EN.
module bus_arbiter_rr
  import bus_arbiter_rr_pkg::*;
#(
  parameter int MASTER_NUM = MASTER_NUM_DEF
`ifdef BUS_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [MASTER_NUM-1:0]         req_i,
  input  logic                          ready_i,
  output logic [MASTER_NUM-1:0]         grant_o,
  output logic [$clog2(MASTER_NUM)-1:0] owner_o,
  output logic                          busy_o
`ifdef BUS_ARB_TIMEOUT_EN
  , output logic                        timeout_o
`endif
);
  localparam int W = $clog2(MASTER_NUM);
  arb_state_e state_q, state_d;
  logic [MASTER_NUM-1:0] grant_q, grant_d;
  logic [W-1:0] owner_q, owner_d, last_q, last_d, pick_idx;
  logic pick_valid, own_req, tmo_hit;
  rr_pick #(.N(MASTER_NUM), .W(W)) u_pick (
    .req_i(req_i),
    .last_i(last_q),
    .idx_o(pick_idx),
    .valid_o(pick_valid)
  );
  assign own_req = |(req_i & grant_q);
`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 255) ? 16 : 8;
  logic [CW-1:0] cnt_q, cnt_d;
  logic timeout_q, timeout_d;
  // completion and withdrawal both take precedence over the watchdog
  assign tmo_hit = state_q == OWNED && cnt_q == CW'(TIMEOUT_CYCLES - 1) && !ready_i && own_req;
  always_comb begin
    cnt_d = state_q == OWNED ? cnt_q + 1'b1 : '0;
    timeout_d = tmo_hit;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout_o = timeout_q;
`else
  assign tmo_hit = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d = last_q;
    if (state_q == IDLE) begin
      if (pick_valid) begin
        state_d = OWNED;
        grant_d = MASTER_NUM'(1) << pick_idx;
        owner_d = pick_idx;
        last_d = pick_idx;
      end
    end else if (ready_i || !own_req || tmo_hit) begin
      state_d = IDLE;
      grant_d = '0;
      owner_d = '0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q <= W'(MASTER_NUM - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q <= last_d;
    end
  end
  assign grant_o = grant_q;
  assign owner_o = owner_q;
  assign busy_o = state_q == OWNED;
endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb_bus_arbiter_rr: directed checks of grant order, hold, release, reset and watchdog
module tb_bus_arbiter_rr;
  import bus_arbiter_rr_pkg::*;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] req_i;
  logic ready_i;
  logic [3:0] grant_o;
  logic [1:0] owner_o;
  logic busy_o;
  int total = 0;
  int bad = 0;
  logic [3:0] exp_seq [9] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
`ifdef BUS_ARB_TIMEOUT_EN
  logic timeout_o;
  bus_arbiter_rr #(.MASTER_NUM(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .ready_i(ready_i),
    .grant_o(grant_o), .owner_o(owner_o), .busy_o(busy_o), .timeout_o(timeout_o)
  );
`else
  bus_arbiter_rr #(.MASTER_NUM(4)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .ready_i(ready_i),
    .grant_o(grant_o), .owner_o(owner_o), .busy_o(busy_o)
  );
`endif
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    req_i = '0;
    ready_i = 1'b0;
    step();
    rst = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    req_i = '0;
    ready_i = 1'b0;
    step();
    step();
    chk("rst_grant", 8'(grant_o), 8'h0);
    chk("rst_owner", 8'(owner_o), 8'h0);
    chk("rst_busy", 8'(busy_o), 8'h0);
    rst = 1'b0;
    step();
    req_i = 4'b0001;
    step();
    chk("single_grant", 8'(grant_o), 8'h1);
    chk("single_busy", 8'(busy_o), 8'h1);
    ready_i = 1'b1;
    step();
    chk("single_release", 8'(grant_o), 8'h0);
    chk("single_idle", 8'(busy_o), 8'h0);
    req_i = '0;
    ready_i = 1'b0;
    do_reset();
    req_i = 4'b1111;
    ready_i = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      chk($sformatf("rr_seq%0d", i), 8'(grant_o), 8'(exp_seq[i]));
    end
    chk("rr_wrap_owner", 8'(owner_o), 8'h0);
    req_i = '0;
    step();
    ready_i = 1'b0;
    req_i = 4'b0100;
    step();
    chk("own2_grant", 8'(grant_o), 8'h4);
    chk("own2_owner", 8'(owner_o), 8'h2);
    req_i = 4'b1101;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("hold%0d", i), 8'(grant_o), 8'h4);
    end
    ready_i = 1'b1;
    step();
    chk("hold_release", 8'(grant_o), 8'h0);
    ready_i = 1'b0;
    step();
    chk("next_owner3", 8'(owner_o), 8'h3);
    chk("next_grant3", 8'(grant_o), 8'h8);
    req_i = 4'b0000;
    step();
    chk("abandon_grant", 8'(grant_o), 8'h0);
    chk("abandon_busy", 8'(busy_o), 8'h0);
`ifdef BUS_ARB_TIMEOUT_EN
    chk("abandon_no_tmo", 8'(timeout_o), 8'h0);
`endif
    ready_i = 1'b1;
    step();
    chk("idle_ready_ignored", 8'(busy_o), 8'h0);
    ready_i = 1'b0;
    do_reset();
    req_i = 4'b0010;
    step();
    chk("pre_rst_grant", 8'(grant_o), 8'h2);
    #2 rst = 1'b1;
    #1 chk("async_rst_grant", 8'(grant_o), 8'h0);
    chk("async_rst_busy", 8'(busy_o), 8'h0);
    #1 rst = 1'b0;
    req_i = 4'b0011;
    step();
    chk("post_rst_first", 8'(grant_o), 8'h1);
`ifdef BUS_ARB_TIMEOUT_EN
    do_reset();
    req_i = 4'b0001;
    step();
    chk("wd_grant", 8'(grant_o), 8'h1);
    for (int i = 0; i < 7; i++) step();
    chk("wd_held_c8", 8'(grant_o), 8'h1);
    chk("wd_quiet_c8", 8'(timeout_o), 8'h0);
    step();
    chk("wd_pulse", 8'(timeout_o), 8'h1);
    chk("wd_release", 8'(grant_o), 8'h0);
    step();
    chk("wd_pulse_once", 8'(timeout_o), 8'h0);
    chk("wd_regrant", 8'(grant_o), 8'h1);
    for (int i = 0; i < 7; i++) step();
    ready_i = 1'b1;
    step();
    chk("wd_ready_wins_tmo", 8'(timeout_o), 8'h0);
    chk("wd_ready_release", 8'(grant_o), 8'h0);
    ready_i = 1'b0;
    req_i = '0;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bus_arbiter_rr.md
BUS_ARBITER_RR -- requirements
Module: bus_arbiter_rr

Interface
REQ-001 Parameter MASTER_NUM, default 4, number of bus masters sharing the slave bus (2..8).
REQ-002 Parameter TIMEOUT_CYCLES, default 255, watchdog limit in clk cycles (used only under BUS_ARB_TIMEOUT_EN).
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req_i  input  MASTER_NUM  per-master bus request, level-held until the transaction completes.
REQ-006 ready_i  input  1  transaction-done indication returned by the slave mux for the current owner.
REQ-007 grant_o  output  MASTER_NUM  one-hot grant; all zero when the bus is idle.
REQ-008 owner_o  output  $clog2(MASTER_NUM)  index of the granted master; 0 when idle.
REQ-009 busy_o  output  1  high while any master owns the bus.
REQ-010 timeout_o  output  1  one-cycle pulse on watchdog abort (present only under BUS_ARB_TIMEOUT_EN).

Function
REQ-011 The block SHALL implement a two-state FSM: IDLE and OWNED.
REQ-012 In IDLE with req_i nonzero, the block SHALL select one master by round-robin and enter OWNED; grant_o, owner_o and busy_o are registered and SHALL appear the cycle after the request is sampled.
REQ-013 The search SHALL start at index (last_owner+1) mod MASTER_NUM and wrap; the first requesting index wins.
REQ-014 last_owner SHALL update to the winner at each grant.
REQ-015 In OWNED, grant SHALL be held unchanged regardless of other requests.
REQ-016 In OWNED, ready_i=1 SHALL end the transaction: next cycle grant_o=0, busy_o=0, state IDLE.
REQ-017 Re-arbitration SHALL not occur in the same cycle as release, so there is exactly one idle turnaround cycle between owners.
REQ-018 In OWNED, if the owner deasserts its req_i without ready_i, the block SHALL release as in REQ-016 (abandoned transaction).
REQ-019 If ready_i=1 and the owner deasserts req_i in the same cycle, the block SHALL treat this as a normal completion.
REQ-020 ready_i in IDLE SHALL be ignored.
REQ-021 A single requesting master SHALL be re-granted after each turnaround cycle (grant every second cycle at most).

Reset
REQ-022 On rst: state IDLE, grant_o=0, owner_o=0, busy_o=0, timeout_o=0, last_owner=MASTER_NUM-1 (master 0 has first priority), watchdog counter=0.
REQ-023 rst asserted mid-transaction SHALL drop the grant immediately (asynchronously), with no completion or timeout reported.

Configuration
REQ-024 Macro BUS_ARB_TIMEOUT_EN: when defined, an 8..16-bit watchdog counter SHALL count cycles in OWNED, clear on every grant, and, on reaching TIMEOUT_CYCLES without ready_i, force release as in REQ-016 and pulse timeout_o for one cycle.
REQ-025 If ready_i arrives on the same cycle the count reaches TIMEOUT_CYCLES, completion SHALL win and timeout_o SHALL stay 0.
REQ-026 Without the macro: no counter, no timeout_o port, and the bus is held until ready_i or request withdrawal.

Structure
REQ-027 MASTER_NUM default, the FSM state enum (IDLE, OWNED) and the TIMEOUT_CYCLES default SHALL live in the shared bus package alongside the bus data-width constants.
REQ-028 The round-robin selection SHALL be a combinational sub-module rr_pick (inputs req and last_owner; outputs winner index and valid); the FSM and registers stay in bus_arbiter_rr.

Verification
REQ-029 Reset then req_i=4'b0001 -> grant_o=4'b0001 one cycle later; ready_i pulse -> grant_o=0 next cycle.
REQ-030 req_i=4'b1111 held with ready_i every OWNED cycle -> grant order 0,1,2,3,0, each separated by one idle cycle.
REQ-031 Owner 2 granted, req_i becomes 4'b1101 while ready_i=0 -> grant_o stays 4'b0100 until ready_i, then the next grant goes to master 3.
REQ-032 Owner drops req_i with no ready_i -> release next cycle; no timeout_o.
REQ-033 BUS_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, ready_i held 0 -> timeout_o pulses once 8 cycles after grant and the bus releases; ready_i on cycle 8 -> no pulse.
REQ-034 rst asserted while master 1 owns the bus -> grant_o=0 immediately; after release, req_i=4'b0011 -> master 0 granted first.
